// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Items shared by the button conditioner and its per-channel debouncer:
//   - db_state_e      : per-button debounce state
//   - DEF_*           : default parameter values for the block
//   - cnt_lsb()       : LSB of button i's counter inside the packed press_cnt bus
//   - db_cnt_w()      : width of the debounce counter for a given stable count
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

  // 1 ms at a 100 MHz ACLK
  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_CNT_W           = 8;

  function automatic int cnt_lsb(input int idx, input int cnt_w);
    return idx * cnt_w;
  endfunction

  // The counter never has to hold more than DEBOUNCE_CYCLES-1.
  function automatic int db_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchronizer, debounce FSM with stable-cycle
// counter, registered debounced level and one-cycle press/release pulses.
//
// Ports:
//   aclk_i     : block clock
//   aresetn_i  : asynchronous active-low reset
//   btn_i      : raw, asynchronous button pin (1 = pressed)
//   level_o    : debounced level
//   press_o    : one-cycle pulse, asserted with the first cycle of level_o=1
//   release_o  : one-cycle pulse, asserted with the first cycle of level_o=0
//
// state     | meaning
// ----------+-----------------------------------------------------------
// STABLE_LO | level 0 accepted, sync matches it
// WAIT_HI   | sync went high, counting consecutive high cycles
// STABLE_HI | level 1 accepted, sync matches it
// WAIT_LO   | sync went low, counting consecutive low cycles
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic aclk_i,
  input  logic aresetn_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int DB_W = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  db_state_e       state_q,   state_d;
  logic [DB_W-1:0] cnt_q,     cnt_d;
  logic            level_q,   level_d;
  logic            press_q,   press_d;
  logic            release_q, release_d;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter holds the number of consecutive cycles the new value has
  // been seen, so loading 1 on the first one makes the compare against
  // DEBOUNCE_CYCLES-1 accept the change on the DEBOUNCE_CYCLES-th cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          cnt_d   = DB_W'(1);
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          cnt_d   = '0;
          state_d = STABLE_LO;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = STABLE_HI;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          cnt_d   = DB_W'(1);
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          cnt_d   = '0;
          state_d = STABLE_HI;
        end else if (cnt_q == DB_LAST) begin
          cnt_d     = '0;
          state_d   = STABLE_LO;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE_LO;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_event_capture.sv
// -----------------------------------------------------------------------------
// btn_event_capture
// Push-button conditioner feeding the register file: debounced levels,
// sticky press/release flags with W1C clear, per-button press counters and
// a registered level interrupt.
//
// Ports:
//   ACLK, ARESETN      : clock, asynchronous active-low reset
//   btn_in             : raw button pins
//   btn_level          : debounced levels
//   press_sticky       : sticky press flags
//   release_sticky     : sticky release flags
//   clr_stb            : W1C strobe, qualifies the two clear masks
//   clr_press_mask     : press_sticky bits to clear
//   clr_release_mask   : release_sticky bits to clear
//   cnt_clr            : zeroes every press counter
//   press_cnt          : packed counters, button i at [i*CNT_W +: CNT_W]
//   irq_en             : per-button interrupt enable
//   irq                : registered OR of enabled sticky flags
// -----------------------------------------------------------------------------
module btn_event_capture
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [NUM_BTN-1:0]       btn_in,
  output logic [NUM_BTN-1:0]       btn_level,
  output logic [NUM_BTN-1:0]       press_sticky,
  output logic [NUM_BTN-1:0]       release_sticky,
  input  logic                     clr_stb,
  input  logic [NUM_BTN-1:0]       clr_press_mask,
  input  logic [NUM_BTN-1:0]       clr_release_mask,
  input  logic                     cnt_clr,
  output logic [NUM_BTN*CNT_W-1:0] press_cnt,
  input  logic [NUM_BTN-1:0]       irq_en,
  output logic                     irq
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_evt;
  logic [NUM_BTN-1:0] release_evt;

  logic [NUM_BTN-1:0] press_q,   press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic               irq_q,     irq_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    localparam int LSB = cnt_lsb(i, CNT_W);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .aclk_i    (ACLK),
      .aresetn_i (ARESETN),
      .btn_i     (btn_in[i]),
      .level_o   (level_w[i]),
      .press_o   (press_evt[i]),
      .release_o (release_evt[i])
    );

    // A clear that lands on a press still records that press.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
        cnt_d = press_evt[i] ? CNT_W'(1) : '0;
      end else if (press_evt[i]) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign press_cnt[LSB +: CNT_W] = cnt_q;
  end

  // Set has priority over clear so an event coinciding with a W1C is kept.
  always_comb begin
    press_d   = press_evt   | (press_q   & ~(clr_stb ? clr_press_mask   : '0));
    release_d = release_evt | (release_q & ~(clr_stb ? clr_release_mask : '0));
    irq_d     = |((press_q | release_q) & irq_en);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      press_q   <= '0;
      release_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      irq_q     <= irq_d;
    end
  end

  assign btn_level      = level_w;
  assign press_sticky   = press_q;
  assign release_sticky = release_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_btn_event_capture.sv
module tb_btn_event_capture;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int CW = 8;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic [NB-1:0]    btn_in;
  logic [NB-1:0]    btn_level;
  logic [NB-1:0]    press_sticky;
  logic [NB-1:0]    release_sticky;
  logic             clr_stb;
  logic [NB-1:0]    clr_press_mask;
  logic [NB-1:0]    clr_release_mask;
  logic             cnt_clr;
  logic [NB*CW-1:0] press_cnt;
  logic [NB-1:0]    irq_en;
  logic             irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  btn_event_capture #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .btn_in(btn_in), .btn_level(btn_level),
    .press_sticky(press_sticky), .release_sticky(release_sticky),
    .clr_stb(clr_stb), .clr_press_mask(clr_press_mask),
    .clr_release_mask(clr_release_mask), .cnt_clr(cnt_clr),
    .press_cnt(press_cnt), .irq_en(irq_en), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  // Behavioural model: sync is the pin seen two edges late; the level flips
  // once sync has disagreed with it for DB consecutive edges. Events show the
  // edge the level flips, flags/counters one edge later, irq one more.
  logic [NB-1:0] m_s1, m_s2, m_level, m_pevt, m_revt, m_ps, m_rs;
  logic          m_irq;
  logic [CW-1:0] m_cnt [NB];
  int            m_run [NB];

  task automatic model_step();
    logic irq_n;
    if (!ARESETN) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pevt = '0; m_revt = '0;
      m_ps = '0; m_rs = '0; m_irq = 1'b0;
      for (int i = 0; i < NB; i++) begin
        m_cnt[i] = '0;
        m_run[i] = 0;
      end
    end else begin
      irq_n = |((m_ps | m_rs) & irq_en);
      for (int i = 0; i < NB; i++) begin
        m_ps[i] = m_pevt[i] | (m_ps[i] & ~(clr_stb & clr_press_mask[i]));
        m_rs[i] = m_revt[i] | (m_rs[i] & ~(clr_stb & clr_release_mask[i]));
        if (cnt_clr) m_cnt[i] = m_pevt[i] ? 8'd1 : 8'd0;
        else if (m_pevt[i]) m_cnt[i] = m_cnt[i] + 8'd1;
        m_pevt[i] = 1'b0;
        m_revt[i] = 1'b0;
        if (m_s2[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_level[i] = m_s2[i];
            if (m_s2[i]) m_pevt[i] = 1'b1;
            else         m_revt[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = btn_in[i];
      end
      m_irq = irq_n;
    end
  endtask

  always @(posedge ACLK or negedge ARESETN) model_step();

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (cmp_en) begin
      chk("cyc_btn_level", 32'(btn_level), 32'(m_level));
      chk("cyc_press_sticky", 32'(press_sticky), 32'(m_ps));
      chk("cyc_release_sticky", 32'(release_sticky), 32'(m_rs));
      chk("cyc_press_cnt", press_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
      chk("cyc_irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0; btn_in = '0; clr_stb = 1'b0; clr_press_mask = '0;
    clr_release_mask = '0; cnt_clr = 1'b0; irq_en = '0;
    cmp_en = 1'b1;
    wait_neg(3);
    chk("reset_level", 32'(btn_level), 0);
    chk("reset_cnt", press_cnt, 0);
    chk("reset_irq", 32'(irq), 0);
    ARESETN = 1'b1;
    wait_neg(2);

    // 1: clean press on btn 0
    btn_in[0] = 1'b1;
    wait_neg(5);
    chk("t1_level_early", 32'(btn_level[0]), 0);
    wait_neg(1);
    chk("t1_level", 32'(btn_level[0]), 1);
    chk("t1_model_level", 32'(m_level[0]), 1);
    chk("t1_sticky_not_yet", 32'(press_sticky), 0);
    wait_neg(1);
    chk("t1_sticky", 32'(press_sticky), 32'h1);
    chk("t1_cnt", 32'(press_cnt[7:0]), 1);
    chk("t1_model_cnt", 32'(m_cnt[0]), 1);
    wait_neg(3);

    // 2: glitches on btn 1
    repeat (5) begin
      btn_in[1] = 1'b1; wait_neg(3);
      btn_in[1] = 1'b0; wait_neg(3);
    end
    wait_neg(6);
    chk("t2_level", 32'(btn_level[1]), 0);
    chk("t2_press", 32'(press_sticky[1]), 0);
    chk("t2_release", 32'(release_sticky[1]), 0);
    chk("t2_cnt", 32'(press_cnt[15:8]), 0);

    // 3: release, irq, W1C
    irq_en = 4'b0001;
    wait_neg(2);
    chk("t3_irq_press", 32'(irq), 1);
    btn_in[0] = 1'b0;
    wait_neg(7);
    chk("t3_release", 32'(release_sticky), 32'h1);
    wait_neg(1);
    chk("t3_irq_release", 32'(irq), 1);
    clr_stb = 1'b1; clr_press_mask = 4'b0001; clr_release_mask = 4'b0001;
    wait_neg(1);
    clr_stb = 1'b0; clr_press_mask = '0; clr_release_mask = '0;
    chk("t3_press_clr", 32'(press_sticky[0]), 0);
    chk("t3_release_clr", 32'(release_sticky[0]), 0);
    chk("t3_irq_lag", 32'(irq), 1);
    wait_neg(1);
    chk("t3_irq_off", 32'(irq), 0);

    // 4: set beats clear on btn 2
    btn_in[2] = 1'b1;
    wait_neg(6);
    clr_stb = 1'b1; clr_press_mask = 4'b0100;
    wait_neg(1);
    clr_stb = 1'b0; clr_press_mask = '0;
    chk("t4_set_wins", 32'(press_sticky[2]), 1);
    wait_neg(1);
    chk("t4_set_holds", 32'(press_sticky[2]), 1);
    btn_in[2] = 1'b0;
    wait_neg(8);

    // 5: counter wrap and clear on btn 3
    for (int k = 0; k < 256; k++) begin
      btn_in[3] = 1'b1; wait_neg(6);
      btn_in[3] = 1'b0; wait_neg(6);
    end
    wait_neg(2);
    chk("t5_wrap", 32'(press_cnt[31:24]), 0);
    chk("t5_model_wrap", 32'(m_cnt[3]), 0);
    btn_in[3] = 1'b1;
    wait_neg(6);
    cnt_clr = 1'b1;
    wait_neg(1);
    cnt_clr = 1'b0;
    chk("t5_clr_with_press", press_cnt, 32'h0100_0000);
    btn_in[3] = 1'b0;
    wait_neg(8);

    // 6: asynchronous reset mid-debounce / mid-press
    btn_in[1] = 1'b1;
    wait_neg(8);
    chk("t6_btn1_level", 32'(btn_level[1]), 1);
    btn_in[0] = 1'b1;
    wait_neg(4);
    #2 ARESETN = 1'b0;
    #1;
    chk("t6_rst_level", 32'(btn_level), 0);
    chk("t6_rst_press", 32'(press_sticky), 0);
    chk("t6_rst_release", 32'(release_sticky), 0);
    chk("t6_rst_cnt", press_cnt, 0);
    chk("t6_rst_irq", 32'(irq), 0);
    btn_in[0] = 1'b0;
    wait_neg(1);
    ARESETN = 1'b1;
    wait_neg(5);
    chk("t6_level_early", 32'(btn_level[1]), 0);
    wait_neg(1);
    chk("t6_level", 32'(btn_level[1]), 1);
    wait_neg(1);
    chk("t6_cnt", 32'(press_cnt[15:8]), 1);
    chk("t6_cnt0", 32'(press_cnt[7:0]), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 5) == 0) btn_in[b] = ~btn_in[b];
      end
      clr_stb          = ($urandom_range(0, 7) == 0);
      clr_press_mask   = 4'($urandom);
      clr_release_mask = 4'($urandom);
      cnt_clr          = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) irq_en = 4'($urandom);
      wait_neg(1);
    end
    clr_stb = 1'b0; cnt_clr = 1'b0;
    wait_neg(10);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
